// File: rtl/dmem_arbiter.sv
// Shares a single-ported data memory between the CPU MEM stage and a debug/loader port.
// Fixed-latency accesses; the CPU is frozen until its access completes and has priority, bounded by a starvation counter.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_ack_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int CNT_W = $clog2(MEM_LAT) + 1;
  localparam int SV_W  = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(MEM_LAT - 1);
  localparam logic [SV_W-1:0]  STARVE_LIM = SV_W'(STARVE_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CPU_ACC,
    S_DBG_ACC,
    S_CPU_DONE,
    S_DBG_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [SV_W-1:0]   r_starve;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dbg_rdata;
  logic              w_gnt_cpu;
  logic              w_gnt_dbg;
  logic              w_acc;
  logic              w_last;

  assign w_acc  = (r_state == S_CPU_ACC) || (r_state == S_DBG_ACC);
  assign w_last = (r_cnt == CNT_LAST);

  // DONE states never grant, so a request still held from the finished access is not re-served.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_cpu   = 1'b0;
    w_gnt_dbg   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (cpu_req_i && (!dbg_req_i || (r_starve < STARVE_LIM))) begin
            w_gnt_cpu   = 1'b1;
            w_state_nxt = S_CPU_ACC;
          end else if (dbg_req_i) begin
            w_gnt_dbg   = 1'b1;
            w_state_nxt = S_DBG_ACC;
          end
        end
      end
      S_CPU_ACC:  if (w_last) w_state_nxt = S_CPU_DONE;
      S_DBG_ACC:  if (w_last) w_state_nxt = S_DBG_DONE;
      S_CPU_DONE: w_state_nxt = S_IDLE;
      S_DBG_DONE: w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_starve    <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_gnt_cpu || w_gnt_dbg) begin
        r_addr  <= w_gnt_cpu ? cpu_addr_i  : dbg_addr_i;
        r_wdata <= w_gnt_cpu ? cpu_wdata_i : dbg_wdata_i;
        r_we    <= w_gnt_cpu ? cpu_we_i    : dbg_we_i;
        r_cnt   <= '0;
      end else if (w_acc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_acc && w_last && !r_we) begin
        if (r_state == S_CPU_ACC) r_cpu_rdata <= mem_rdata_i;
        else                      r_dbg_rdata <= mem_rdata_i;
      end
      // Starvation is only tracked while debug is actually waiting in IDLE.
      if (r_state == S_IDLE) begin
        if (w_gnt_dbg || !dbg_req_i) r_starve <= '0;
        else if (w_gnt_cpu && (r_starve != STARVE_LIM)) r_starve <= r_starve + SV_W'(1);
      end
    end
  end

  assign mem_en_o    = w_acc;
  assign mem_we_o    = w_acc && r_we && w_last;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign cpu_rdata_o = r_cpu_rdata;
  assign dbg_rdata_o = r_dbg_rdata;
  assign dbg_ack_o   = (r_state == S_DBG_DONE);
  assign cpu_stall_o = rst_i && cpu_req_i && (r_state != S_CPU_DONE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a 16-word memory model answers the memory port, a reference
// memory array and a starvation rule model give the expected results.
module tb_dmem_arbiter;

  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic          cpu_req_i;
  logic          cpu_we_i;
  logic [AW-1:0] cpu_addr_i;
  logic [DW-1:0] cpu_wdata_i;
  logic [DW-1:0] cpu_rdata_o;
  logic          cpu_stall_o;
  logic          dbg_req_i;
  logic          dbg_we_i;
  logic [AW-1:0] dbg_addr_i;
  logic [DW-1:0] dbg_wdata_i;
  logic [DW-1:0] dbg_rdata_o;
  logic          dbg_ack_o;
  logic          mem_en_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;

  int checks;
  int failures;

  always #5 clk_i = ~clk_i;

  dmem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_rdata_o(dbg_rdata_o), .dbg_ack_o(dbg_ack_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  // Memory model: read data is only meaningful on the final access cycle.
  logic [DW-1:0] mem     [16];
  logic [DW-1:0] ref_mem [16];
  logic          bd_we;
  logic [3:0]    bd_idx;
  logic [DW-1:0] bd_data;
  int            en_run;
  int            strobe_cnt;

  always @(posedge clk_i) begin
    if (bd_we)         mem[bd_idx] <= bd_data;
    else if (mem_we_o) mem[mem_addr_o[5:2]] <= mem_wdata_o;
    if (mem_we_o) strobe_cnt <= strobe_cnt + 1;
    en_run <= mem_en_o ? en_run + 1 : 0;
  end

  assign mem_rdata_i = (mem_en_o && en_run == MEM_LAT - 1) ? mem[mem_addr_o[5:2]] : 32'hDEAD_BEEF;

  task automatic preload(input int idx, input logic [DW-1:0] v);
    bd_idx  = idx[3:0];
    bd_data = v;
    bd_we   = 1'b1;
    @(posedge clk_i); #1;
    bd_we        = 1'b0;
    ref_mem[idx] = v;
  endtask

  task automatic do_cpu(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        output int stall_n, output int en_n, output int strobes, output int we_at,
                        output logic [DW-1:0] rd, output bit tmo);
    int s0;
    s0 = strobe_cnt; stall_n = 0; en_n = 0; we_at = -1; tmo = 1'b1; rd = '0;
    cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wd; cpu_req_i = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (mem_en_o) en_n++;
      if (mem_we_o && we_at < 0) we_at = c;
      if (cpu_stall_o) stall_n++;
      else begin
        rd = cpu_rdata_o; tmo = 1'b0;
        break;
      end
    end
    @(posedge clk_i); #1;
    cpu_req_i = 1'b0; cpu_we_i = 1'b0;
    strobes = strobe_cnt - s0;
  endtask

  task automatic do_dbg(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        output int ack_at, output int stall_seen, output int strobes,
                        output logic ack2, output logic [DW-1:0] rd, output bit tmo);
    int s0;
    s0 = strobe_cnt; ack_at = -1; stall_seen = 0; tmo = 1'b1; rd = '0;
    dbg_we_i = we; dbg_addr_i = addr; dbg_wdata_i = wd; dbg_req_i = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (cpu_stall_o) stall_seen++;
      if (dbg_ack_o) begin
        ack_at = c; rd = dbg_rdata_o; tmo = 1'b0;
        break;
      end
    end
    @(posedge clk_i); #1;
    dbg_req_i = 1'b0; dbg_we_i = 1'b0;
    @(negedge clk_i);
    ack2 = dbg_ack_o;
    @(posedge clk_i); #1;
    strobes = strobe_cnt - s0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; start_i = 1'b0; cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = '0;
    cpu_wdata_i = '0; dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
    bd_we = 1'b0; bd_idx = '0; bd_data = '0;
    for (int i = 0; i < 16; i++) preload(i, $urandom);
    @(negedge clk_i);
    checks++;
    if ({cpu_stall_o, mem_en_o, mem_we_o, dbg_ack_o} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl: stall/en/we/ack=%b expected 0000",
               {cpu_stall_o, mem_en_o, mem_we_o, dbg_ack_o});
    end
    checks++;
    if (mem_addr_o !== '0 || mem_wdata_o !== '0) begin
      failures++;
      $display("FAIL reset_mem_bus: addr=%h wdata=%h expected 0", mem_addr_o, mem_wdata_o);
    end
    checks++;
    if (cpu_rdata_o !== '0 || dbg_rdata_o !== '0) begin
      failures++;
      $display("FAIL reset_rdata: cpu=%h dbg=%h expected 0", cpu_rdata_o, dbg_rdata_o);
    end
    cpu_req_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b1;
  endtask

  task automatic test_cpu_read();
    int sn, en, sb, wa; logic [DW-1:0] rd; bit tmo;
    preload(0, 32'd5);
    do_cpu(1'b0, 32'h0, '0, sn, en, sb, wa, rd, tmo);
    checks++;
    if (tmo || sn != MEM_LAT + 1) begin
      failures++; $display("FAIL cpu_read_stall: stall=%0d timeout=%0d expected %0d", sn, tmo, MEM_LAT + 1);
    end
    checks++;
    if (en != MEM_LAT) begin
      failures++; $display("FAIL cpu_read_en: en cycles=%0d expected %0d", en, MEM_LAT);
    end
    checks++;
    if (rd !== 32'd5 || sb != 0) begin
      failures++; $display("FAIL cpu_read_data: rdata=%0d strobes=%0d expected 5 and 0", rd, sb);
    end
  endtask

  task automatic test_cpu_write();
    int sn, en, sb, wa; logic [DW-1:0] rd; bit tmo;
    do_cpu(1'b1, 32'h8, 32'd10, sn, en, sb, wa, rd, tmo);
    ref_mem[2] = 32'd10;
    checks++;
    if (sb != 1 || wa != MEM_LAT) begin
      failures++; $display("FAIL cpu_write_strobe: strobes=%0d at=%0d expected 1 at %0d", sb, wa, MEM_LAT);
    end
    checks++;
    if (mem[2] !== 32'd10 || tmo || sn != MEM_LAT + 1) begin
      failures++; $display("FAIL cpu_write_mem: word2=%0d stall=%0d expected 10 and %0d", mem[2], sn, MEM_LAT + 1);
    end
  endtask

  task automatic test_dbg_read();
    int aa, ss, sb; logic a2; logic [DW-1:0] rd; bit tmo;
    preload(1, 32'd7);
    do_dbg(1'b0, 32'h4, '0, aa, ss, sb, a2, rd, tmo);
    checks++;
    if (tmo || rd !== 32'd7 || aa != MEM_LAT + 1) begin
      failures++; $display("FAIL dbg_read: rdata=%0d ack_at=%0d expected 7 at %0d", rd, aa, MEM_LAT + 1);
    end
    checks++;
    if (ss != 0 || a2 !== 1'b0 || sb != 0) begin
      failures++; $display("FAIL dbg_read_side: stall=%0d ack2=%b strobes=%0d expected 0", ss, a2, sb);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      int idx; logic we; logic [DW-1:0] wd, rd; bit tmo; int a, b, sb, d;
      idx = $urandom_range(15); we = 1'($urandom_range(1)); wd = $urandom;
      if ($urandom_range(1) == 0) begin
        do_cpu(we, 32'(idx * 4), wd, a, b, sb, d, rd, tmo);
        checks++;
        if (tmo || a != MEM_LAT + 1) begin
          failures++; $display("FAIL rand_cpu_stall[%0d]: stall=%0d expected %0d", k, a, MEM_LAT + 1);
        end
      end else begin
        logic a2;
        do_dbg(we, 32'(idx * 4), wd, a, b, sb, a2, rd, tmo);
        checks++;
        if (tmo || b != 0 || a2 !== 1'b0) begin
          failures++; $display("FAIL rand_dbg_ack[%0d]: timeout=%0d stall=%0d ack2=%b expected 0", k, tmo, b, a2);
        end
      end
      checks++;
      if (we) begin
        ref_mem[idx] = wd;
        if (sb != 1 || mem[idx] !== wd) begin
          failures++; $display("FAIL rand_write[%0d]: strobes=%0d word=%h expected 1 and %h", k, sb, mem[idx], wd);
        end
      end else if (sb != 0 || rd !== ref_mem[idx]) begin
        failures++; $display("FAIL rand_read[%0d]: strobes=%0d rdata=%h expected 0 and %h", k, sb, rd, ref_mem[idx]);
      end
    end
  endtask

  task automatic test_contention();
    int a_idx, b_idx, starve_m, nd, nc_after, nev;
    bit dbg_pend, got_c, got_d, exp_d;
    a_idx = 3; b_idx = 9;
    cpu_we_i = 1'b0; cpu_addr_i = 32'(a_idx * 4); cpu_req_i = 1'b1;
    dbg_we_i = 1'b0; dbg_addr_i = 32'(b_idx * 4); dbg_req_i = 1'b1;
    dbg_pend = 1'b1; starve_m = 0; nd = 0; nc_after = 0; nev = 0;
    for (int cyc = 0; cyc < 300 && nd < 2; cyc++) begin
      @(negedge clk_i);
      got_c = cpu_req_i && !cpu_stall_o;
      got_d = dbg_ack_o;
      if (got_c || got_d) begin
        exp_d = dbg_pend && (starve_m >= STARVE_MAX);
        checks++;
        if (got_d !== exp_d || got_c === got_d) begin
          failures++; $display("FAIL contention_order[%0d]: dbg=%b cpu=%b expected dbg=%b", nev, got_d, got_c, exp_d);
        end
        checks++;
        if (got_d ? (dbg_rdata_o !== ref_mem[b_idx]) : (cpu_rdata_o !== ref_mem[a_idx])) begin
          failures++; $display("FAIL contention_data[%0d]: cpu=%h dbg=%h", nev, cpu_rdata_o, dbg_rdata_o);
        end
        if (exp_d) starve_m = 0;
        else if (dbg_pend) starve_m = (starve_m < STARVE_MAX) ? starve_m + 1 : STARVE_MAX;
        else starve_m = 0;
        nev++;
        if (got_d) begin
          nd++; nc_after = 0;
          @(posedge clk_i); #1;
          dbg_req_i = 1'b0; dbg_pend = 1'b0;
        end else if (!dbg_pend) begin
          nc_after++;
          if (nc_after == 2 && nd == 1) begin
            @(posedge clk_i); #1;
            dbg_req_i = 1'b1; dbg_pend = 1'b1;
          end
        end
      end
    end
    checks++;
    if (nd != 2 || nev != 12) begin
      failures++; $display("FAIL contention_count: dbg grants=%0d events=%0d expected 2 and 12", nd, nev);
    end
    cpu_req_i = 1'b0; dbg_req_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset_mid();
    int idx, s0, sn; logic [DW-1:0] wd; bit done;
    idx = $urandom_range(15); wd = $urandom;
    s0 = strobe_cnt;
    cpu_we_i = 1'b1; cpu_addr_i = 32'(idx * 4); cpu_wdata_i = wd; cpu_req_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({mem_en_o, mem_we_o, cpu_stall_o} !== 3'b000 || mem_addr_o !== '0 || cpu_rdata_o !== '0) begin
      failures++; $display("FAIL reset_mid_outputs: en/we/stall=%b addr=%h rdata=%h expected 0",
                           {mem_en_o, mem_we_o, cpu_stall_o}, mem_addr_o, cpu_rdata_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    checks++;
    if (strobe_cnt != s0 || mem[idx] !== ref_mem[idx]) begin
      failures++; $display("FAIL reset_mid_nostrobe: strobes=%0d word=%h expected 0 and %h",
                           strobe_cnt - s0, mem[idx], ref_mem[idx]);
    end
    sn = 0; done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (cpu_stall_o) sn++;
      else begin done = 1'b1; break; end
    end
    @(posedge clk_i); #1;
    cpu_req_i = 1'b0; cpu_we_i = 1'b0;
    ref_mem[idx] = wd;
    checks++;
    if (!done || sn != MEM_LAT + 1 || strobe_cnt - s0 != 1 || mem[idx] !== wd) begin
      failures++; $display("FAIL reset_mid_retry: stall=%0d strobes=%0d word=%h expected %0d, 1, %h",
                           sn, strobe_cnt - s0, mem[idx], MEM_LAT + 1, wd);
    end
  endtask

  task automatic test_start_gate();
    int idx, sn, bad; bit done;
    idx = $urandom_range(15);
    start_i = 1'b0;
    cpu_we_i = 1'b0; cpu_addr_i = 32'(idx * 4); cpu_req_i = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      if (!cpu_stall_o || mem_en_o) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL start_block: bad cycles=%0d expected 0", bad);
    end
    @(posedge clk_i); #1;
    start_i = 1'b1;
    sn = 0; done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (cpu_stall_o) sn++;
      else begin done = 1'b1; break; end
    end
    checks++;
    if (!done || sn != MEM_LAT + 1 || cpu_rdata_o !== ref_mem[idx]) begin
      failures++; $display("FAIL start_release: stall=%0d rdata=%h expected %0d and %h",
                           sn, cpu_rdata_o, MEM_LAT + 1, ref_mem[idx]);
    end
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    sn = 0; done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (cpu_stall_o) sn++;
      else begin done = 1'b1; break; end
    end
    checks++;
    if (!done || sn != MEM_LAT) begin
      failures++; $display("FAIL start_drop_mid: stall after drop=%0d done=%0d expected %0d", sn, done, MEM_LAT);
    end
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      if (!cpu_stall_o || mem_en_o) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL start_drop_nogrant: bad cycles=%0d expected 0", bad);
    end
    @(posedge clk_i); #1;
    cpu_req_i = 1'b0; start_i = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_dbg_read();
    test_random();
    test_contention();
    test_reset_mid();
    test_start_gate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
